// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the sequential AES MixColumns engine: input state channel,
// output state channel and the busy indicator.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns, one 32-bit column per clock through a single shared column unit.
// Bypass copies columns unchanged so the final round keeps identical timing.
module mix_columns_seq (
  input  logic             clk,
  input  logic             rst,
  mix_columns_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] in_q, in_d;
  logic [127:0] res_q, res_d;
  logic         byp_q, byp_d;

  logic [31:0]  col_in;
  logic [31:0]  col_mixed;
  logic [31:0]  col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 byte sits in the MSB of the column word.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  always_comb begin
    col_in = in_q[127:96];
    case (col_q)
      2'd0: col_in = in_q[127:96];
      2'd1: col_in = in_q[95:64];
      2'd2: col_in = in_q[63:32];
      2'd3: col_in = in_q[31:0];
      default: col_in = in_q[127:96];
    endcase
  end

  assign col_mixed = mix_column(col_in);
  assign col_out   = byp_q ? col_in : col_mixed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      in_q    <= '0;
      res_q   <= '0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      in_q    <= in_d;
      res_q   <= res_d;
      byp_q   <= byp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    in_d         = in_q;
    res_d        = res_q;
    byp_d        = byp_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          in_d    = bus.in_state;
          byp_d   = bus.in_bypass;
          res_d   = '0;
          col_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        bus.busy = 1'b1;
        case (col_q)
          2'd0: res_d[127:96] = col_out;
          2'd1: res_d[95:64]  = col_out;
          2'd2: res_d[63:32]  = col_out;
          2'd3: res_d[31:0]   = col_out;
          default: res_d = res_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          col_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        bus.out_valid = 1'b1;
        // Returning to IDLE here never accepts input on the same edge.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.out_state = res_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and streaming checks for mix_columns_seq: known vectors, latency,
// backpressure, mid-operation reset and a 1000-state regression with inverse check.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mix_columns_seq_if bus();

  mix_columns_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_IN   = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FIPS_OUT  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] MIXED_IN  = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
  localparam logic [127:0] MIXED_OUT = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // General GF(2^8) multiply used by a circulant-matrix reference.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [7:0] k0,
                                             input logic [7:0] k1, input logic [7:0] k2,
                                             input logic [7:0] k3);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    coef[0] = k0; coef[1] = k1; coef[2] = k2; coef[3] = k3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - row + 4) % 4], a[j]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, 128'(bus.in_ready), 128'(1));
  endtask

  // Send one state, check latency and result, optionally stall in DONE, then drain.
  task automatic transact(input string tag, input logic [127:0] s, input logic b,
                          input logic [127:0] exp, input int hold);
    int lat;
    wait_ready(tag);
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_bypass = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(4));
    check({tag, " out_state"}, bus.out_state, exp);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid  = i[0];
      bus.in_state  = rand128();
      bus.in_bypass = i[1];
      @(negedge clk);
      check({tag, " hold out_state"}, bus.out_state, exp);
      check({tag, " hold in_ready"}, 128'(bus.in_ready), 128'(0));
      check({tag, " hold out_valid"}, 128'(bus.out_valid), 128'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " in_ready after drain"}, 128'(bus.in_ready), 128'(1));
    check({tag, " out_valid after drain"}, 128'(bus.out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] src_q [$];
    logic [127:0] exp_q [$];
    logic         byp_q [$];
    logic [127:0] s, e;
    logic         b;
    int           sent, got, cyc;

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset in_ready", 128'(bus.in_ready), 128'(1));
    check("reset out_valid", 128'(bus.out_valid), 128'(0));
    check("reset busy", 128'(bus.busy), 128'(0));
    check("reset out_state", bus.out_state, '0);
    rst = 1'b0;
    @(negedge clk);

    transact("fips", FIPS_IN, 1'b0, FIPS_OUT, 0);
    transact("fips bypass", FIPS_IN, 1'b1, FIPS_IN, 0);
    transact("mixed", MIXED_IN, 1'b0, MIXED_OUT, 0);
    transact("backpressure", FIPS_IN, 1'b0, FIPS_OUT, 10);
    transact("after backpressure", MIXED_IN, 1'b0, MIXED_OUT, 0);

    // Reset lands on the edge ending the second BUSY cycle.
    wait_ready("reset mid");
    bus.in_valid  = 1'b1;
    bus.in_state  = FIPS_IN;
    bus.in_bypass = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid busy", 128'(bus.busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset in_ready", 128'(bus.in_ready), 128'(1));
    check("mid reset out_valid", 128'(bus.out_valid), 128'(0));
    check("mid reset busy", 128'(bus.busy), 128'(0));
    check("mid reset out_state", bus.out_state, '0);
    transact("after reset", FIPS_IN, 1'b0, FIPS_OUT, 0);

    // Streaming regression with in_valid and out_ready held high.
    sent = 0;
    got  = 0;
    cyc  = 0;
    bus.out_ready = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected output", 128'(1), 128'(0));
        end else begin
          s = src_q.pop_front();
          e = exp_q.pop_front();
          b = byp_q.pop_front();
          check("stream out_state", bus.out_state, e);
          if (!b) check("stream inverse", mat_apply(bus.out_state, 8'h0e, 8'h0b, 8'h0d, 8'h09), s);
          got++;
        end
      end
      if (bus.in_ready && sent < 1000) begin
        s = rand128();
        b = ($urandom_range(7) == 0);
        bus.in_valid  = 1'b1;
        bus.in_state  = s;
        bus.in_bypass = b;
        src_q.push_back(s);
        exp_q.push_back(b ? s : mat_apply(s, 8'h02, 8'h03, 8'h01, 8'h01));
        byp_q.push_back(b);
        sent++;
      end else begin
        bus.in_valid  = (sent < 1000);
        bus.in_state  = rand128();
        bus.in_bypass = $urandom_range(1) == 1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream count", 128'(got), 128'(1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Forward AES MixColumns engine for the encryption datapath; the counterpart of the decryption InvMixColumns helper.
- Accepts a 128-bit state over a valid/ready handshake and processes one 32-bit column per clock through a single shared GF(2^8) column unit.
- Returns the mixed state over a second valid/ready handshake.
- Sits between ShiftRows and AddRoundKey in the round pipeline. A bypass flag lets the final round pass the state through with the same timing.

Parameters:
- None. The block is fixed to the AES 128-bit state of 4 columns × 4 bytes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_state / in_bypass are valid
- in_ready  output  1  block can accept a state
- in_state  input  128  state; column c = bits [127-32c -: 32], row-0 byte in the MSB of each column
- in_bypass  input  1  1 = output equals input (final round)
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  mixed state, same byte layout as in_state
- busy  output  1  1 while columns are being processed (BUSY state)

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM=IDLE, col counter=0, in_ready=1, out_valid=0, busy=0, out_state=0, internal state and bypass registers=0.
  - Reset has priority over everything, including mid-BUSY and DONE. Any in-flight state is discarded and no out_valid is produced for it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. At an edge where in_valid=1, capture in_state and in_bypass, clear the result register, set col=0, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge writes column col of the result register, then col increments. At the edge where col=3 is written, go to DONE and set col back to 0.
  - DONE: out_valid=1, out_state=result register, in_ready=0. Hold until an edge with out_ready=1, then go to IDLE.
- Handshakes:
  - in_ready=1 only in IDLE.
  - No same-cycle turnaround: the DONE→IDLE edge never also accepts input, so in_ready rises the cycle after the output handshake.
  - Throughput is therefore at most one state per 6 cycles.
- Latency: acceptance at edge k; columns 0..3 are written at edges k+1..k+4; out_valid=1 from edge k+4 onward.
- While out_valid=1 and out_ready=0, out_state is stable and in_state changes are ignored.
- Column arithmetic, for input bytes a0..a3 (a0 = row 0):
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
  - 2·x = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00)
  - 3·x = 2·x ^ x
  - Pure combinational xtime, no lookup tables. One column unit, muxed by col.
- Bypass=1: each BUSY edge copies the input column unchanged. Latency and handshakes are identical to bypass=0.
- Composing this block with the decryption InvMixColumns helper must give identity on every column.

Test Plan:
- FIPS-197 vector, bypass=0: in_state=db135345_f20a225c_01010101_2d26314c → out_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid exactly 4 cycles after acceptance.
- Same in_state with bypass=1 → out_state equals in_state; same latency.
- Mixed columns: c6c6c6c6_d4d4d4d5_00000000_ffffffff → c6c6c6c6_d5d5d7d6_00000000_ffffffff.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_state → out_state stable, in_ready=0 throughout. Raise out_ready → in_ready=1 one cycle later. Next accepted state is processed correctly.
- Reset mid-operation: assert rst at the 2nd BUSY cycle → next cycle in_ready=1, out_valid=0, busy=0, out_state=0. A subsequent state completes normally.
- Random regression of 1000 states against a reference model:
  - Back-to-back in_valid → every output matches the model.
  - Applying InvMixColumns to each output returns the original input.
